// File: rtl/td4_pkg.sv
// ----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 core support logic.
//   - run_state_e : run-controller state encoding (IDLE/LOAD/RUN/HALT), which
//                   is also the value presented on the controller's state port
//   - TD4_ADDR_W  : default program-memory address width (16 words)
//   - TD4_DATA_W  : default instruction width
//   - TD4_CNT_W   : default cycle counter / budget width
// ----------------------------------------------------------------------------
package td4_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;
    localparam int TD4_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } run_state_e;

endpackage

// File: rtl/td4_run_ctrl.sv
// ----------------------------------------------------------------------------
// td4_run_ctrl
// Run controller for the TD4 core and its writable program memory. It loads a
// program image over a valid/ready byte stream while holding the CPU in
// reset, then sequences execution with run / halt / single-step commands and
// an optional cycle budget. It owns the CPU clock enable and reset and
// multiplexes the program-memory port between the loader and CPU fetch.
//
// Ports
//   CLK, CLR             clock; synchronous active-high reset
//   cmd_load/run/halt/step  commands, priority load > halt > run > step
//   run_budget           cycle limit latched on entry to RUN (0 = unlimited)
//   ld_valid, ld_data    loader byte stream in; ld_ready out
//   cpu_rst, cpu_ce      CPU reset and clock enable (from registered state only)
//   cpu_a, cpu_d         CPU fetch address in, instruction out
//   mem_a/wd/we, mem_rd  program-memory port (combinational read data)
//   state                current state (IDLE=0, LOAD=1, RUN=2, HALT=3)
//   cycle_cnt            executed-instruction count, saturating
//   done                 one-cycle pulse when the budget stops a run
// ----------------------------------------------------------------------------
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W,
    parameter int CNT_W  = TD4_CNT_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    input  logic [CNT_W-1:0]  run_budget,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_rst,
    output logic              cpu_ce,
    input  logic [ADDR_W-1:0] cpu_a,
    output logic [DATA_W-1:0] cpu_d,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              done
);

    run_state_e        st_q, st_d;
    logic [ADDR_W-1:0] la_q, la_d;        // load address
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  budget_q, budget_d;
    logic              step_q, step_d;    // high for the one single-step cycle
    logic              done_q, done_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              budget_hit;
    logic              xfer;

    // Saturating increment shared by free-running RUN cycles and single steps.
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign budget_hit = (budget_q != '0) && (cnt_inc >= budget_q);
    assign xfer       = (st_q == ST_LOAD) && ld_valid;

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (CLR) begin
            st_q     <= ST_IDLE;
            la_q     <= '0;
            cnt_q    <= '0;
            budget_q <= '0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            la_q     <= la_d;
            cnt_q    <= cnt_d;
            budget_q <= budget_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        // NOTE: every value gets a default before the case so that no path
        // leaves a variable unassigned, which would infer a latch.
        st_d     = st_q;
        la_d     = la_q;
        cnt_d    = cnt_q;
        budget_d = budget_q;
        step_d   = 1'b0;
        done_d   = 1'b0;

        unique case (st_q)
            ST_IDLE: begin
                if (cmd_load) begin
                    st_d = ST_LOAD;
                    la_d = '0;
                end else if (cmd_run) begin
                    st_d     = ST_RUN;
                    cnt_d    = '0;
                    budget_d = run_budget;
                end
            end

            // Commands are deliberately ignored here; only CLR aborts a load.
            ST_LOAD: begin
                if (xfer) begin
                    la_d = la_q + ADDR_W'(1);
                    if (la_q == '1) st_d = ST_IDLE;
                end
            end

            // Every RUN cycle executes one instruction, including the cycle in
            // which a halt is sampled.
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (cmd_load) begin
                    st_d = ST_LOAD;
                    la_d = '0;
                end else if (cmd_halt || budget_hit) begin
                    st_d   = ST_HALT;
                    done_d = budget_hit;
                end
            end

            // A step cycle (step_q) counts its instruction when it ends. The
            // step flag blocks re-triggering, so a held cmd_step steps every
            // second cycle. cmd_halt is meaningless here and does not block it.
            ST_HALT: begin
                if (step_q) cnt_d = cnt_inc;
                if (cmd_load) begin
                    st_d = ST_LOAD;
                    la_d = '0;
                end else if (cmd_run) begin
                    st_d     = ST_RUN;
                    budget_d = run_budget;
                end else if (cmd_step && !step_q) begin
                    step_d = 1'b1;
                end
            end

            default: st_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state only, never from the cmd_* inputs.
    assign state     = st_q;
    assign ld_ready  = (st_q == ST_LOAD);
    assign cpu_rst   = (st_q == ST_IDLE) || (st_q == ST_LOAD);
    assign cpu_ce    = (st_q == ST_RUN) || step_q;
    assign cycle_cnt = cnt_q;
    assign done      = done_q;

    // Memory port: the loader owns it in LOAD, CPU fetch otherwise.
    assign mem_we = xfer;
    assign mem_wd = ld_data;
    assign mem_a  = (st_q == ST_LOAD) ? la_q : cpu_a;
    assign cpu_d  = (st_q == ST_LOAD) ? '0 : mem_rd;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_td4_run_ctrl
// Self-checking bench for td4_run_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are observed on the falling edge. A behavioural
// program memory sits on the mem_* port; expected program contents and run
// lengths are derived from the loaded image and budget arithmetic.
// ----------------------------------------------------------------------------
module tb_td4_run_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic              CLK = 1'b0;
    logic              CLR;
    logic              cmd_load, cmd_run, cmd_halt, cmd_step;
    logic [CNT_W-1:0]  run_budget;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              cpu_rst, cpu_ce;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_d;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] img  [DEPTH];   // image the bench expects in memory
    logic [DATA_W-1:0] pmem [DEPTH];   // behavioural program memory
    int                ce_seen;
    int                done_seen;
    logic [ADDR_W-1:0] wa_q [$];
    logic [DATA_W-1:0] wd_q [$];

    always #5 CLK = ~CLK;

    td4_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .CLR(CLR),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
        .run_budget(run_budget),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .state(state), .cycle_cnt(cycle_cnt), .done(done)
    );

    always @(posedge CLK) if (mem_we) pmem[mem_a] <= mem_wd;
    assign mem_rd = pmem[mem_a];

    // Event monitor: counts executed cycles, done pulses and memory writes.
    always @(negedge CLK) begin
        if (!CLR) begin
            if (cpu_ce) ce_seen++;
            if (done) done_seen++;
            if (mem_we) begin
                wa_q.push_back(mem_a);
                wd_q.push_back(mem_wd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        @(negedge CLK);
    endtask

    task automatic random_image;
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    endtask

    // Issue cmd_load and stream nbytes of img. mode 0: no gaps, 1: every 3rd
    // cycle idle, 2: random gaps. ok reports whether all bytes were taken.
    task automatic do_load(input int mode, input int nbytes, output bit ok);
        int  i;
        int  k;
        bit  gap;
        i = 0;
        k = 0;
        cmd_load = 1'b1;
        next_cycle;
        cmd_load = 1'b0;
        while (i < nbytes && k < 200) begin
            gap      = (mode == 1 && k % 3 == 2) || (mode == 2 && $urandom_range(0, 2) == 0);
            ld_valid = !gap;
            ld_data  = gap ? 8'($urandom) : img[i];
            settle;
            if (ld_valid && ld_ready) i++;
            next_cycle;
            k++;
        end
        ld_valid = 1'b0;
        ok = (i == nbytes);
    endtask

    task automatic test_reset;
        CLR = 1'b1;
        next_cycle;
        next_cycle;
        settle;
        n_checks++;
        if ({state, cpu_rst, cpu_ce, ld_ready, done, mem_we} !== {S_IDLE, 5'b10000})
            $display("FAIL reset_outputs: got state=%0d rst=%b ce=%b rdy=%b done=%b we=%b, expected 0 1 0 0 0 0",
                     state, cpu_rst, cpu_ce, ld_ready, done, mem_we);
        else n_pass++;
        n_checks++;
        if (cycle_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt);
        else n_pass++;
        next_cycle;
        CLR = 1'b0;
    endtask

    task automatic test_load;
        bit ok;
        int errs;
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        wa_q.delete();
        wd_q.delete();
        do_load(1, DEPTH, ok);
        n_checks++;
        if (!ok) $display("FAIL load_timeout: loader did not accept 16 bytes");
        else n_pass++;
        settle;
        n_checks++;
        if ({state, ld_ready, cpu_rst} !== {S_IDLE, 2'b01})
            $display("FAIL load_end_state: got state=%0d rdy=%b rst=%b expected 0 0 1", state, ld_ready, cpu_rst);
        else n_pass++;
        n_checks++;
        if (wa_q.size() != DEPTH) $display("FAIL load_write_count: got %0d expected %0d", wa_q.size(), DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== 4'(i) || wd_q[i] !== img[i])
                $display("FAIL load_write_%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, wa_q[i], wd_q[i], i, img[i]);
            else n_pass++;
        end
        errs = 0;
        next_cycle;
    endtask

    // From IDLE (start must be 0) or HALT with cycle_cnt == start: run with the
    // given nonzero budget until the budget stops execution.
    task automatic test_budget_run(input int budget, input int start);
        int exp_runs;
        int exp_cnt;
        bit halted;
        exp_runs  = (budget > start) ? budget - start : 1;
        exp_cnt   = start + exp_runs;
        halted    = 1'b0;
        ce_seen   = 0;
        done_seen = 0;
        run_budget = 16'(budget);
        cmd_run    = 1'b1;
        next_cycle;
        cmd_run    = 1'b0;
        run_budget = 16'($urandom);  // latched on entry, later changes must not matter
        for (int c = 0; c < exp_runs + 20 && !halted; c++) begin
            cpu_a = 4'($urandom);
            settle;
            if (c == 0) begin
                n_checks++;
                if ({cpu_rst, cpu_ce} !== 2'b01)
                    $display("FAIL run_latency: got rst=%b ce=%b expected 0 1", cpu_rst, cpu_ce);
                else n_pass++;
            end
            if (state === S_HALT) begin
                halted = 1'b1;
                n_checks++;
                if (done !== 1'b1) $display("FAIL done_first_halt: got %b expected 1", done);
                else n_pass++;
            end else begin
                n_checks++;
                if ({cpu_d, mem_a, mem_we} !== {img[cpu_a], cpu_a, 1'b0})
                    $display("FAIL fetch_a%0d: got d=%h a=%0d we=%b expected d=%h a=%0d we=0",
                             cpu_a, cpu_d, mem_a, mem_we, img[cpu_a], cpu_a);
                else n_pass++;
            end
            next_cycle;
        end
        n_checks++;
        if (!halted) $display("FAIL budget_timeout: budget %0d never halted", budget);
        else n_pass++;
        next_cycle;
        settle;
        n_checks++;
        if (ce_seen != exp_runs) $display("FAIL budget_ce_cycles: got %0d expected %0d", ce_seen, exp_runs);
        else n_pass++;
        n_checks++;
        if (done_seen != 1) $display("FAIL budget_done_pulses: got %0d expected 1", done_seen);
        else n_pass++;
        n_checks++;
        if ({state, cycle_cnt} !== {S_HALT, 16'(exp_cnt)})
            $display("FAIL budget_end: got state=%0d cnt=%0d expected 3 %0d", state, cycle_cnt, exp_cnt);
        else n_pass++;
        next_cycle;
    endtask

    task automatic test_halt_step_resume;
        CLR = 1'b1;
        next_cycle;
        CLR = 1'b0;
        run_budget = 16'd0;
        cmd_run    = 1'b1;
        next_cycle;
        cmd_run = 1'b0;
        repeat (3) next_cycle;
        cmd_halt = 1'b1;
        settle;
        n_checks++;
        if (cpu_ce !== 1'b1) $display("FAIL halt_cycle_ce: got %b expected 1", cpu_ce);
        else n_pass++;
        next_cycle;
        cmd_halt = 1'b0;
        settle;
        n_checks++;
        if ({state, cpu_ce, cpu_rst, done, cycle_cnt} !== {S_HALT, 3'b000, 16'd4})
            $display("FAIL halted: got state=%0d ce=%b rst=%b done=%b cnt=%0d expected 3 0 0 0 4",
                     state, cpu_ce, cpu_rst, done, cycle_cnt);
        else n_pass++;
        next_cycle;

        ce_seen   = 0;
        done_seen = 0;
        for (int s = 0; s < 2; s++) begin
            cmd_step = 1'b1;
            next_cycle;
            cmd_step = 1'b0;
            settle;
            n_checks++;
            if (cpu_ce !== 1'b1) $display("FAIL step%0d_ce: got %b expected 1", s, cpu_ce);
            else n_pass++;
            next_cycle;
            settle;
            n_checks++;
            if (cpu_ce !== 1'b0) $display("FAIL step%0d_ce_after: got %b expected 0", s, cpu_ce);
            else n_pass++;
            next_cycle;
        end
        settle;
        n_checks++;
        if (ce_seen != 2 || done_seen != 0 || cycle_cnt !== 16'd6)
            $display("FAIL steps: got ce=%0d done=%0d cnt=%0d expected 2 0 6", ce_seen, done_seen, cycle_cnt);
        else n_pass++;
        next_cycle;

        ce_seen  = 0;
        cmd_step = 1'b1;
        repeat (6) next_cycle;
        cmd_step = 1'b0;
        next_cycle;
        settle;
        n_checks++;
        if (ce_seen != 3 || cycle_cnt !== 16'd9)
            $display("FAIL held_step: got ce=%0d cnt=%0d expected 3 9", ce_seen, cycle_cnt);
        else n_pass++;
        next_cycle;

        run_budget = 16'd0;
        cmd_run    = 1'b1;
        next_cycle;
        cmd_run = 1'b0;
        settle;
        n_checks++;
        if ({state, cpu_ce, cycle_cnt} !== {S_RUN, 1'b1, 16'd9})
            $display("FAIL resume: got state=%0d ce=%b cnt=%0d expected 2 1 9", state, cpu_ce, cycle_cnt);
        else n_pass++;
        next_cycle;
        settle;
        n_checks++;
        if (cycle_cnt !== 16'd10) $display("FAIL resume_count: got %0d expected 10", cycle_cnt);
        else n_pass++;
        next_cycle;
    endtask

    task automatic test_priority;
        // In RUN: halt beats run.
        cmd_halt = 1'b1;
        cmd_run  = 1'b1;
        next_cycle;
        cmd_halt = 1'b0;
        cmd_run  = 1'b0;
        settle;
        n_checks++;
        if ({state, cpu_ce} !== {S_HALT, 1'b0})
            $display("FAIL prio_halt_run: got state=%0d ce=%b expected 3 0", state, cpu_ce);
        else n_pass++;
        next_cycle;
        // In HALT: load beats run, CPU goes back into reset.
        cmd_load = 1'b1;
        cmd_run  = 1'b1;
        next_cycle;
        cmd_load = 1'b0;
        cmd_run  = 1'b0;
        settle;
        n_checks++;
        if ({state, cpu_rst, ld_ready, cpu_ce, cpu_d} !== {S_LOAD, 3'b110, 8'h00})
            $display("FAIL prio_load_run: got state=%0d rst=%b rdy=%b ce=%b d=%h expected 1 1 1 0 00",
                     state, cpu_rst, ld_ready, cpu_ce, cpu_d);
        else n_pass++;
        next_cycle;
        // Commands are ignored inside LOAD.
        cmd_run = 1'b1;
        next_cycle;
        cmd_run = 1'b0;
        settle;
        n_checks++;
        if (state !== S_LOAD) $display("FAIL load_ignores_run: got state=%0d expected 1", state);
        else n_pass++;
        next_cycle;
        CLR = 1'b1;
        next_cycle;
        CLR = 1'b0;
        // In RUN: load leaves cpu_rst low this cycle, reasserts it next cycle.
        run_budget = 16'd0;
        cmd_run    = 1'b1;
        next_cycle;
        cmd_run  = 1'b0;
        cmd_load = 1'b1;
        cmd_halt = 1'b1;
        settle;
        n_checks++;
        if ({cpu_rst, cpu_ce} !== 2'b01) $display("FAIL run_load_same_cycle: got rst=%b ce=%b expected 0 1", cpu_rst, cpu_ce);
        else n_pass++;
        next_cycle;
        cmd_load = 1'b0;
        cmd_halt = 1'b0;
        settle;
        n_checks++;
        if ({state, cpu_rst} !== {S_LOAD, 1'b1})
            $display("FAIL run_load_next: got state=%0d rst=%b expected 1 1", state, cpu_rst);
        else n_pass++;
        next_cycle;
        CLR = 1'b1;
        next_cycle;
        CLR = 1'b0;
    endtask

    task automatic test_abort;
        bit ok;
        int errs;
        random_image();
        wa_q.delete();
        wd_q.delete();
        do_load(0, 7, ok);
        CLR = 1'b1;
        next_cycle;
        CLR = 1'b0;
        settle;
        n_checks++;
        if (!ok || {state, ld_ready, cpu_rst} !== {S_IDLE, 2'b01} || wa_q.size() != 7)
            $display("FAIL abort: got ok=%b state=%0d rdy=%b rst=%b writes=%0d expected 1 0 0 1 7",
                     ok, state, ld_ready, cpu_rst, wa_q.size());
        else n_pass++;
        next_cycle;
        random_image();
        wa_q.delete();
        wd_q.delete();
        do_load(2, DEPTH, ok);
        n_checks++;
        if (!ok || wa_q.size() == 0 || wa_q[0] !== 4'd0)
            $display("FAIL reload_first_addr: got ok=%b addr=%0d expected 1 0", ok, wa_q.size() ? wa_q[0] : 4'hx);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 4'(i) || wd_q[i] !== img[i]) errs++;
        n_checks++;
        if (errs != 0 || wa_q.size() != DEPTH)
            $display("FAIL reload_writes: got %0d bad of %0d writes expected 0 of %0d", errs, wa_q.size(), DEPTH);
        else n_pass++;
    endtask

    task automatic test_random;
        bit ok;
        int errs;
        int b1;
        int b2;
        for (int it = 0; it < 4; it++) begin
            random_image();
            wa_q.delete();
            wd_q.delete();
            do_load(2, DEPTH, ok);
            errs = 0;
            for (int i = 0; i < wa_q.size(); i++)
                if (wa_q[i] !== 4'(i) || wd_q[i] !== img[i]) errs++;
            n_checks++;
            if (!ok || errs != 0 || wa_q.size() != DEPTH)
                $display("FAIL rand_load_%0d: got ok=%b bad=%0d writes=%0d expected 1 0 %0d",
                         it, ok, errs, wa_q.size(), DEPTH);
            else n_pass++;
            b1 = $urandom_range(1, 20);
            test_budget_run(b1, 0);
            b2 = $urandom_range(1, 30);
            test_budget_run(b2, b1);
        end
    endtask

    initial begin
        CLR        = 1'b1;
        cmd_load   = 1'b0;
        cmd_run    = 1'b0;
        cmd_halt   = 1'b0;
        cmd_step   = 1'b0;
        run_budget = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        cpu_a      = '0;
        ce_seen    = 0;
        done_seen  = 0;
        next_cycle;

        test_reset();
        test_load();
        test_budget_run(5, 0);
        test_halt_step_resume();
        test_priority();
        test_abort();
        test_budget_run(3, 0);
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/td4_run_ctrl.md
# td4_run_ctrl

Run controller for the TD4 core and its 16×8 program memory. It loads a program image into writable program memory over a byte-stream handshake and holds the CPU in reset while it does so. It then sequences execution with run, halt and single-step commands and an optional cycle budget. It owns the CPU's clock enable and reset, and multiplexes the program-memory port between the loader and CPU fetch.

## Interface
Parameters:
- ADDR_W, 4, program-memory address width (depth 2^ADDR_W)
- DATA_W, 8, instruction width
- CNT_W, 16, cycle counter / budget width

Ports:
- CLK  in  1  system clock
- CLR  in  1  reset, synchronous, active-high
- cmd_load  in  1  start loading a program image (level sampled each cycle)
- cmd_run  in  1  start or resume execution
- cmd_halt  in  1  pause execution
- cmd_step  in  1  execute one instruction while halted
- run_budget  in  CNT_W  cycle limit; 0 means unlimited; latched on entry to RUN
- ld_valid  in  1  loader byte valid
- ld_data  in  DATA_W  loader byte
- ld_ready  out  1  controller accepts byte
- cpu_rst  out  1  CPU reset, active-high
- cpu_ce  out  1  CPU clock enable; one instruction executes per high cycle
- cpu_a  in  ADDR_W  CPU fetch address
- cpu_d  out  DATA_W  instruction to CPU
- mem_a  out  ADDR_W  program-memory address
- mem_wd  out  DATA_W  program-memory write data
- mem_we  out  1  program-memory write enable
- mem_rd  in  DATA_W  program-memory read data (combinational read)
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
- cycle_cnt  out  CNT_W  executed-instruction count
- done  out  1  one-cycle pulse on budget exhaustion

## Operation
- Reset values: state=IDLE, cpu_rst=1, cpu_ce=0, ld_ready=0, mem_we=0, cycle_cnt=0, done=0, load address=0, latched budget=0.
- Command priority when several commands are high in the same cycle: load > halt > run > step. Commands that are invalid in the current state are ignored.
- IDLE: cpu_rst=1.
  - cmd_load → LOAD, load address cleared to 0.
  - cmd_run → RUN, cycle_cnt cleared, budget latched.
- LOAD: cpu_rst=1, ld_ready=1.
  - Transfer occurs when ld_valid and ld_ready are both high: mem_we=1, mem_a=load address, mem_wd=ld_data; load address increments.
  - The transfer at address 2^ADDR_W−1 wraps the address to 0 and moves to IDLE.
  - All cmd_* are ignored in LOAD; only CLR aborts it. Memory contents written so far are kept.
- RUN: cpu_rst=0, cpu_ce=1 every cycle, and cycle_cnt increments every cycle (saturating at all-ones).
  - cmd_halt → HALT. The cycle in which cmd_halt is sampled still has cpu_ce=1.
  - Budget ≠ 0 and the incremented cycle_cnt ≥ budget → HALT, with done=1 in the first HALT cycle.
  - cmd_load → LOAD, with cpu_rst reasserted from the next cycle.
- HALT: cpu_rst=0, cpu_ce=0.
  - cmd_step raises cpu_ce for exactly the next cycle and increments cycle_cnt; done is never raised by a step.
  - cmd_run → RUN and relatches the budget; cycle_cnt is not cleared on resume.
  - cmd_load → LOAD.
- Memory mux:
  - In LOAD: mem_a is the load address; cpu_d is forced to 0.
  - Otherwise: mem_a=cpu_a, cpu_d=mem_rd, mem_we=0.

## Timing
- All state registers update on the rising edge of CLK. cpu_rst and cpu_ce decode combinationally from registered state and the registered step flag.
- cpu_ce and cpu_rst are never combinationally dependent on cmd_* inputs.
- LOAD throughput: 1 byte per cycle. A full 16-byte load takes 16 transfer cycles plus 1 cycle to re-enter IDLE.
- RUN latency: cmd_run sampled at edge N gives cpu_rst=0 and cpu_ce=1 from cycle N+1.
- Halt latency: cmd_halt sampled at edge N gives cpu_ce=0 from cycle N+1.
- Step: cmd_step sampled at edge N in HALT gives cpu_ce=1 for cycle N+1 only. A held cmd_step yields one step per 2 cycles.
- CLR sampled high at any edge returns to reset values at that edge, mid-load or mid-run included.

## Structure
- Shared package td4_pkg holds:
  - state encoding constants (IDLE/LOAD/RUN/HALT)
  - ADDR_W/DATA_W defaults
- Single module. No sub-module is required; the FSM, load counter, cycle counter and memory mux are all internal.

## Test plan
- Reset: CLR high 2 cycles → state=0, cpu_rst=1, cpu_ce=0, ld_ready=0, cycle_cnt=0.
- Load: cmd_load, then 16 bytes 0x00..0x0F with ld_valid gapped every 3rd cycle → mem_we exactly 16 times at addresses 0..15, then state=IDLE, ld_ready=0.
- Budget run: run_budget=5, cmd_run pulse → cpu_ce high exactly 5 cycles, cycle_cnt=5, done pulses once, state=HALT.
- Halt/step/resume: budget 0, run 3 cycles, cmd_halt → cycle_cnt=4 (halt cycle included). Then 2 step pulses → cycle_cnt=6, each with a single cpu_ce cycle. Then cmd_run resumes with cycle_cnt continuing from 6.
- Priority: cmd_halt and cmd_run high together in RUN → HALT. cmd_load and cmd_run together in HALT → LOAD with cpu_rst=1.
- Abort: CLR asserted after 7 loaded bytes → state=IDLE, load address=0. A fresh load then starts writing at address 0.
